// File: rtl/tsn_cbs_pkg.sv
// Shared definitions for the TSN CBS ingress path.
// Holds the default tdest width, the counter width and the frame router state encoding.
package tsn_cbs_pkg;

   localparam int DEST_WIDTH_DEFAULT = 3;
   localparam int CNT_W              = 32;

   typedef enum logic [1:0] {
      SOF  = 2'd0,
      FWD  = 2'd1,
      DROP = 2'd2
   } route_state_e;

endpackage

// File: rtl/tdest_frame_router_if.sv
// Byte-wide AXI-Stream bundle with tdest and a 2-bit tuser.
// VALID_W is 1 on the classifier side and NUM_QUEUES on the per-class side.
// On the per-class side tvalid and tready are one bit per output.
//   master : drives tdata/tvalid/tlast/tuser/tdest, samples tready
//   slave  : samples tdata/tvalid/tlast/tuser/tdest, drives tready
interface tdest_frame_router_if #(
   parameter int VALID_W    = 1,
   parameter int DEST_WIDTH = tsn_cbs_pkg::DEST_WIDTH_DEFAULT
);
   logic [7:0]            tdata;
   logic [VALID_W-1:0]    tvalid;
   logic [VALID_W-1:0]    tready;
   logic                  tlast;
   logic [1:0]            tuser;
   logic [DEST_WIDTH-1:0] tdest;

   modport master (output tdata, tvalid, tlast, tuser, tdest, input tready);
   modport slave  (input tdata, tvalid, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/tdest_frame_router_axis_reg_slice_1beat.sv
// One-beat output register for the frame router.
// It holds data/last/user plus the selected output index.
// Ports:
//   clk, rstn           clock; synchronous active-low reset
//   load                capture in_* this cycle (only asserted on an accepted forwarded beat)
//   in_data/last/user   incoming beat
//   in_sel              output index of the incoming beat
//   m_ready             per-output ready
//   in_ready            slice can take a beat this cycle
//   m_data/last/user    held beat, broadcast
//   m_valid             one-hot valid of the held beat
module axis_reg_slice_1beat #(
   parameter int NUM_QUEUES = 8,
   parameter int SEL_W      = 3
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  load,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   input  logic [1:0]            in_user,
   input  logic [SEL_W-1:0]      in_sel,
   input  logic [NUM_QUEUES-1:0] m_ready,
   output logic                  in_ready,
   output logic [7:0]            m_data,
   output logic                  m_last,
   output logic [1:0]            m_user,
   output logic [NUM_QUEUES-1:0] m_valid
);
   logic             valid_q, valid_d;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic [1:0]       user_q, user_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             drain;

   assign drain    = valid_q & m_ready[sel_q];
   // Ready while empty or while the held beat leaves this cycle, so a drain
   // and a load can share a cycle at full throughput.
   assign in_ready = !valid_q | m_ready[sel_q];

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      last_d  = last_q;
      user_d  = user_q;
      sel_d   = sel_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = in_data;
         last_d  = in_last;
         user_d  = in_user;
         sel_d   = in_sel;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
         user_q  <= '0;
         sel_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         user_q  <= user_d;
         sel_q   <= sel_d;
      end
   end

   assign m_data  = data_q;
   assign m_last  = last_q;
   assign m_user  = user_q;
   assign m_valid = valid_q ? (NUM_QUEUES'(1) << sel_q) : '0;

endmodule

// File: rtl/tdest_frame_router.sv
// Steers whole frames from the classifier stream to NUM_QUEUES per-class streams.
// The route is taken from tdest on the first beat of a frame and held until tlast.
// Frames with tdest >= NUM_QUEUES are consumed and counted in drop_count.
// Ports:
//   clk, rstn     clock; synchronous active-low reset
//   s_axis        classifier stream (slave, VALID_W = 1)
//   m_axis        per-class streams (master, VALID_W = NUM_QUEUES); data/last/user broadcast
//   drop_count    frames discarded for an out-of-range tdest (wraps)
//   frame_count   only with TDEST_FRAME_ROUTER_STATS_EN: 32-bit completed-frame
//                 counter per output, output q in bits [32*q +: 32]
//
// state | meaning
// SOF   | next accepted beat is a first beat; tdest decides the route
// FWD   | mid-frame, beats go to the latched output
// DROP  | mid-frame, beats are accepted and discarded
module tdest_frame_router
   import tsn_cbs_pkg::*;
#(
   parameter int NUM_QUEUES = 8,
   parameter int DEST_WIDTH = DEST_WIDTH_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rstn,
   tdest_frame_router_if.slave         s_axis,
   tdest_frame_router_if.master        m_axis,
`ifdef TDEST_FRAME_ROUTER_STATS_EN
   output logic [CNT_W*NUM_QUEUES-1:0] frame_count,
`endif
   output logic [CNT_W-1:0]            drop_count
);
   localparam int SEL_W = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
   localparam logic [DEST_WIDTH:0] NQ_LIM = (DEST_WIDTH+1)'(NUM_QUEUES);

   route_state_e          state_q, state_d;
   logic [SEL_W-1:0]      sel_q, sel_d, route_sel;
   logic [CNT_W-1:0]      drop_count_q, drop_count_d;
   logic                  s_ready, s_fire, dest_ok, fwd_load;
   logic [NUM_QUEUES-1:0] m_valid;
   logic                  m_last;

   assign dest_ok = {1'b0, s_axis.tdest} < NQ_LIM;
   assign s_fire  = s_axis.tvalid[0] & s_ready;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      drop_count_d = drop_count_q;
      route_sel    = sel_q;
      fwd_load     = 1'b0;
      case (state_q)
         SOF: begin
            route_sel = s_axis.tdest[SEL_W-1:0];
            if (s_fire) begin
               if (dest_ok) begin
                  sel_d    = route_sel;
                  fwd_load = 1'b1;
                  state_d  = s_axis.tlast ? SOF : FWD;
               end else begin
                  drop_count_d = drop_count_q + CNT_W'(1);
                  state_d      = s_axis.tlast ? SOF : DROP;
               end
            end
         end
         FWD: begin
            fwd_load = s_fire;
            if (s_fire && s_axis.tlast) state_d = SOF;
         end
         DROP: begin
            if (s_fire && s_axis.tlast) state_d = SOF;
         end
         default: state_d = SOF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= SOF;
         sel_q        <= '0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         drop_count_q <= drop_count_d;
      end
   end

   axis_reg_slice_1beat #(
      .NUM_QUEUES (NUM_QUEUES),
      .SEL_W      (SEL_W)
   ) u_out_reg (
      .clk      (clk),
      .rstn     (rstn),
      .load     (fwd_load),
      .in_data  (s_axis.tdata),
      .in_last  (s_axis.tlast),
      .in_user  (s_axis.tuser),
      .in_sel   (route_sel),
      .m_ready  (m_axis.tready),
      .in_ready (s_ready),
      .m_data   (m_axis.tdata),
      .m_last   (m_last),
      .m_user   (m_axis.tuser),
      .m_valid  (m_valid)
   );

   assign s_axis.tready = s_ready;
   assign m_axis.tvalid = m_valid;
   assign m_axis.tlast  = m_last;
   assign m_axis.tdest  = '0;
   assign drop_count    = drop_count_q;

`ifdef TDEST_FRAME_ROUTER_STATS_EN
   logic [NUM_QUEUES-1:0][CNT_W-1:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      for (int q = 0; q < NUM_QUEUES; q++) begin
         if (m_valid[q] && m_axis.tready[q] && m_last)
            frame_count_d[q] = frame_count_q[q] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) frame_count_q <= '0;
      else       frame_count_q <= frame_count_d;
   end

   assign frame_count = frame_count_q;
`endif

endmodule
